level_sequencer: RTL and testbench
==================================

Name: level_sequencer

Overview:
Game-flow controller that drives the 4-bit `level` input of the background/colour generator in the VGA pipeline.
- Sequences levels 1..MAX_LEVEL from start/level_up/abort pulses.
- Applies every level change only on a frame boundary (rising edge of v_blank_in), so the generator never changes colour mid-frame.
- Holds a timed transition phase between levels and reports game-won.

Parameters:
MAX_LEVEL, 9, highest level; reaching it and requesting up enters WIN (legal range 2..15).
TRANSITION_FRAMES, 60, frame boundaries spent in TRANS after each level increment (legal range 1..255).
AUTO_FRAMES, 600, frames in PLAY before an automatic level_up (used only with LEVEL_AUTO_ADVANCE_EN; 16-bit counter).

Ports:
clk  in  1  posedge clock, same pixel clock as the VGA timing chain
rst_n  in  1  asynchronous active-low reset
v_blank_in  in  1  vertical blank from the timing generator; its rising edge is the frame tick
start  in  1  single-cycle pulse: begin a game / restart after WIN
level_up  in  1  single-cycle pulse: current level completed
abort  in  1  single-cycle pulse: return to IDLE
level  out  4  level to the generator; always in 1..MAX_LEVEL
playing  out  1  high in PLAY
in_transition  out  1  high in TRANS
game_won  out  1  high in WIN
frames_left  out  8  remaining TRANS frames; 0 outside TRANS

Behaviour:
- Reset (async assert, sync release): state=IDLE, level=1, all flags 0, frames_left=0, pending requests cleared, vblank_q=1. Setting vblank_q=1 prevents a spurious tick if v_blank_in is high at release.
- frame_tick = v_blank_in & ~vblank_q. vblank_q is v_blank_in registered.
- All outputs are registered. A change decided at a tick becomes visible 1 clk after the cycle in which v_blank_in is first sampled high.
- Pending flags start_p, up_p and abort_p:
  - set by their pulse;
  - cleared when consumed at a tick;
  - a pulse arriving in the tick cycle itself counts for that tick (flag OR pulse).
- Priority at a tick: abort > start > level_up.
- IDLE: level=1. Tick with start → PLAY. level_up is dropped.
- PLAY: playing=1. Tick with up:
  - if level < MAX_LEVEL: level+1, frames_left=TRANSITION_FRAMES, → TRANS;
  - if level == MAX_LEVEL: → WIN, level unchanged.
- TRANS: in_transition=1. Each tick decrements frames_left. The tick where frames_left==1 → PLAY with frames_left=0. level_up pulses during TRANS are discarded and never latched.
- WIN: game_won=1. Tick with start → level=1, PLAY.
- abort at a tick, from any non-IDLE state: → IDLE, level=1, frames_left=0.
- Pulses wider than 1 cycle behave as one request.
- Unused state encodings recover to IDLE with level=1.

Optional Feature:
LEVEL_AUTO_ADVANCE_EN
- Defined: a 16-bit frame counter runs in PLAY, cleared on entry to PLAY and on every consumed up. When it reaches AUTO_FRAMES at a tick, that tick is treated as an up request. Explicit and auto requests on the same tick count as one.
- Undefined: no counter is built; levels advance only via level_up.

Decomposition:
- Package level_seq_pkg: state encoding (IDLE, PLAY, TRANS, WIN; 2 bits), LEVEL_W=4, FRAMES_W=8, AUTO_W=16.
- Sub-module frame_tick_gen: v_blank_in rising-edge detector with async active-low reset to 1. It is reusable by other frame-synchronous blocks.

Test Plan:
1. Reset with v_blank_in held high, release, toggle vblank 3 frames with no pulses → level=1, playing=0, no tick on the release cycle.
2. start mid-frame, then tick → playing=1 one clk after the tick. Then level_up mid-frame with TRANSITION_FRAMES=3 → at next tick level=2, in_transition=1, frames_left=3. frames_left goes 2, 1, then PLAY at the 3rd tick, frames_left=0.
3. level_up during TRANS → ignored; level stays 2 after returning to PLAY.
4. With MAX_LEVEL=3, reach level 3, then level_up → game_won=1, level=3. start → level=1, playing=1 at next tick.
5. abort and level_up pulsed in the same cycle as a tick during PLAY at level 2 → IDLE, level=1, in_transition=0.
6. With LEVEL_AUTO_ADVANCE_EN and AUTO_FRAMES=5 → level increments at the 5th tick in PLAY with no level_up. Repeat with level_up at tick 5 → single increment only.

Source files
------------

// File: rtl/level_seq_pkg.sv
// Shared encodings and widths for the level sequencer and its frame-synchronous helpers.
package level_seq_pkg;

    localparam int LEVEL_W  = 4;
    localparam int FRAMES_W = 8;
    localparam int AUTO_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_TRANS = 2'd2,
        ST_WIN   = 2'd3
    } state_t;

endpackage

// File: rtl/frame_tick_gen.sv
// One-cycle frame tick on the rising edge of v_blank_in.
// The history flop resets to 1 so a blank already active at reset release is not a tick.
module frame_tick_gen (
    input  logic clk,
    input  logic rst_n,
    input  logic v_blank_in,
    output logic frame_tick
);

    logic vblank_q;

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vblank_q <= 1'b1;
        end else begin
            vblank_q <= v_blank_in;
        end
    end

    assign frame_tick = v_blank_in & ~vblank_q;

endmodule

// File: rtl/level_sequencer.sv
// Game-flow controller driving the colour generator's level; all changes land on frame ticks.
// Optional build macro LEVEL_AUTO_ADVANCE_EN adds an automatic level_up after AUTO_FRAMES frames in PLAY.
module level_sequencer
    import level_seq_pkg::*;
#(
    parameter int MAX_LEVEL         = 9,
    parameter int TRANSITION_FRAMES = 60,
    parameter int AUTO_FRAMES       = 600
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                v_blank_in,
    input  logic                start,
    input  logic                level_up,
    input  logic                abort,
    output logic [LEVEL_W-1:0]  level,
    output logic                playing,
    output logic                in_transition,
    output logic                game_won,
    output logic [FRAMES_W-1:0] frames_left
);

    localparam logic [LEVEL_W-1:0]  LEVEL_ONE  = LEVEL_W'(1);
    localparam logic [LEVEL_W-1:0]  MAX_LVL    = LEVEL_W'(MAX_LEVEL);
    localparam logic [FRAMES_W-1:0] TRANS_INIT = FRAMES_W'(TRANSITION_FRAMES);

    if (MAX_LEVEL < 2 || MAX_LEVEL > 15 || TRANSITION_FRAMES < 1 || TRANSITION_FRAMES > 255 ||
        AUTO_FRAMES < 1 || AUTO_FRAMES > 65535) begin : g_param_check
        $error("level_sequencer: parameter out of legal range");
    end

    state_t                state_q, state_d;
    logic [LEVEL_W-1:0]    level_d;
    logic [FRAMES_W-1:0]   frames_d;
    logic                  frame_tick;
    logic                  start_q, up_q, abort_q;
    logic                  start_rise, up_rise, abort_rise;
    logic                  start_p, up_p, abort_p;
    logic                  start_req, up_req, abort_req;

    frame_tick_gen u_tick (
        .clk        (clk),
        .rst_n      (rst_n),
        .v_blank_in (v_blank_in),
        .frame_tick (frame_tick)
    );

    // Edge detection makes a held pulse count as a single request.
    assign start_rise = start & ~start_q;
    assign up_rise    = level_up & ~up_q;
    assign abort_rise = abort & ~abort_q;

    assign start_req = start_p | start_rise;
    assign abort_req = abort_p | abort_rise;

`ifdef LEVEL_AUTO_ADVANCE_EN
    localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_FRAMES - 1);

    logic [AUTO_W-1:0] auto_cnt;
    logic              auto_hit;

    assign auto_hit = frame_tick && (state_q == ST_PLAY) && (auto_cnt == AUTO_LAST);
    assign up_req   = up_p | up_rise | auto_hit;

    // Any consumed up leaves PLAY, so "not staying in PLAY" covers both clear conditions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            auto_cnt <= '0;
        end else if (state_q != ST_PLAY || state_d != ST_PLAY) begin
            auto_cnt <= '0;
        end else if (frame_tick) begin
            auto_cnt <= auto_cnt + AUTO_W'(1);
        end
    end
`else
    assign up_req = up_p | up_rise;
`endif

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        state_d  = state_q;
        level_d  = level;
        frames_d = frames_left;
        if (frame_tick && abort_req) begin
            state_d  = ST_IDLE;
            level_d  = LEVEL_ONE;
            frames_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    level_d  = LEVEL_ONE;
                    frames_d = '0;
                    if (frame_tick && start_req) state_d = ST_PLAY;
                end
                ST_PLAY: begin
                    if (frame_tick && up_req) begin
                        if (level < MAX_LVL) begin
                            level_d  = level + LEVEL_W'(1);
                            frames_d = TRANS_INIT;
                            state_d  = ST_TRANS;
                        end else begin
                            state_d = ST_WIN;
                        end
                    end
                end
                ST_TRANS: begin
                    if (frame_tick) begin
                        if (frames_left <= FRAMES_W'(1)) begin
                            frames_d = '0;
                            state_d  = ST_PLAY;
                        end else begin
                            frames_d = frames_left - FRAMES_W'(1);
                        end
                    end
                end
                ST_WIN: begin
                    if (frame_tick && start_req) begin
                        level_d = LEVEL_ONE;
                        state_d = ST_PLAY;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    level_d  = LEVEL_ONE;
                    frames_d = '0;
                end
            endcase
        end
    end

    // Every tick consumes or discards all pending requests; level_up is never latched in TRANS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= 1'b0;
            up_q    <= 1'b0;
            abort_q <= 1'b0;
            start_p <= 1'b0;
            up_p    <= 1'b0;
            abort_p <= 1'b0;
        end else begin
            start_q <= start;
            up_q    <= level_up;
            abort_q <= abort;
            if (frame_tick) begin
                start_p <= 1'b0;
                up_p    <= 1'b0;
                abort_p <= 1'b0;
            end else begin
                start_p <= start_p | start_rise;
                up_p    <= up_p | (up_rise && state_q != ST_TRANS);
                abort_p <= abort_p | abort_rise;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            level         <= LEVEL_ONE;
            frames_left   <= '0;
            playing       <= 1'b0;
            in_transition <= 1'b0;
            game_won      <= 1'b0;
        end else begin
            state_q       <= state_d;
            level         <= level_d;
            frames_left   <= frames_d;
            playing       <= (state_d == ST_PLAY);
            in_transition <= (state_d == ST_TRANS);
            game_won      <= (state_d == ST_WIN);
        end
    end

endmodule

// File: tb/tb_level_sequencer.sv
// Table-driven frame-by-frame bench for level_sequencer with a scoreboard of expected outputs.
// The auto-advance section follows the LEVEL_AUTO_ADVANCE_EN build macro.
module tb_level_sequencer;

    localparam int MAX_LEVEL         = 3;
    localparam int TRANSITION_FRAMES = 3;
    localparam int AUTO_FRAMES       = 5;

    localparam logic [2:0] NONE = 3'b000;
    localparam logic [2:0] S    = 3'b100;
    localparam logic [2:0] U    = 3'b010;
    localparam logic [2:0] A    = 3'b001;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       v_blank_in;
    logic       start;
    logic       level_up;
    logic       abort;
    logic [3:0] level;
    logic       playing;
    logic       in_transition;
    logic       game_won;
    logic [7:0] frames_left;

    always #5 clk = ~clk;

    level_sequencer #(
        .MAX_LEVEL         (MAX_LEVEL),
        .TRANSITION_FRAMES (TRANSITION_FRAMES),
        .AUTO_FRAMES       (AUTO_FRAMES)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .v_blank_in    (v_blank_in),
        .start         (start),
        .level_up      (level_up),
        .abort         (abort),
        .level         (level),
        .playing       (playing),
        .in_transition (in_transition),
        .game_won      (game_won),
        .frames_left   (frames_left)
    );

    // mid: pulses {start,level_up,abort} mid-frame; at_tick: pulses in the tick cycle;
    // hold: keep the mid pulses high through the tick and two cycles beyond.
    typedef struct {
        logic [2:0] mid;
        logic [2:0] at_tick;
        logic       hold;
        logic [3:0] lvl;
        logic       play;
        logic       trans;
        logic       won;
        logic [7:0] frames;
    } vec_t;

    typedef struct {
        int         id;
        logic [3:0] lvl;
        logic       play;
        logic       trans;
        logic       won;
        logic [7:0] frames;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    function automatic void add(input logic [2:0] mid, input logic [2:0] at_tick, input logic hold,
                                input int lvl, input int p, input int t, input int w, input int fr);
        vec_t v;
        v.mid     = mid;
        v.at_tick = at_tick;
        v.hold    = hold;
        v.lvl     = 4'(lvl);
        v.play    = (p != 0);
        v.trans   = (t != 0);
        v.won     = (w != 0);
        v.frames  = 8'(fr);
        vecs.push_back(v);
    endfunction

    task automatic compare_front();
        exp_t e;
        e = sb.pop_front();
        check($sformatf("v%0d level", e.id), {4'b0, level}, {4'b0, e.lvl});
        check($sformatf("v%0d playing", e.id), {7'b0, playing}, {7'b0, e.play});
        check($sformatf("v%0d in_transition", e.id), {7'b0, in_transition}, {7'b0, e.trans});
        check($sformatf("v%0d game_won", e.id), {7'b0, game_won}, {7'b0, e.won});
        check($sformatf("v%0d frames_left", e.id), frames_left, e.frames);
    endtask

    task automatic run_frame(input vec_t v, input int id);
        exp_t e;
        @(negedge clk);
        {start, level_up, abort} = v.mid;
        @(negedge clk);
        if (!v.hold) {start, level_up, abort} = NONE;
        repeat (2) @(negedge clk);
        v_blank_in = 1'b1;
        {start, level_up, abort} = (v.hold ? v.mid : NONE) | v.at_tick;
        e.id = id; e.lvl = v.lvl; e.play = v.play; e.trans = v.trans; e.won = v.won; e.frames = v.frames;
        sb.push_back(e);
        @(negedge clk);
        compare_front();
        if (v.hold) repeat (2) @(negedge clk);
        {start, level_up, abort} = NONE;
        repeat (2) @(negedge clk);
        v_blank_in = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; v_blank_in = 1'b1; start = 1'b0; level_up = 1'b0; abort = 1'b0;
        #12;
        check("reset level", {4'b0, level}, 8'd1);
        check("reset playing", {7'b0, playing}, 8'd0);
        check("reset in_transition", {7'b0, in_transition}, 8'd0);
        check("reset game_won", {7'b0, game_won}, 8'd0);
        check("reset frames_left", frames_left, 8'd0);

        // Release with blank already high and a start pulse: no tick may fire here.
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("release no tick playing", {7'b0, playing}, 8'd0);
        repeat (3) @(negedge clk);
        check("release held blank playing", {7'b0, playing}, 8'd0);
        v_blank_in = 1'b0;
        repeat (3) @(negedge clk);

        add(A,    NONE,  0, 1, 0, 0, 0, 0);  // abort drops the start latched at release
        add(NONE, NONE,  0, 1, 0, 0, 0, 0);
        add(NONE, NONE,  0, 1, 0, 0, 0, 0);
        add(NONE, NONE,  0, 1, 0, 0, 0, 0);
        add(U,    NONE,  0, 1, 0, 0, 0, 0);  // level_up dropped in IDLE
        add(NONE, NONE,  0, 1, 0, 0, 0, 0);
        add(S,    NONE,  0, 1, 1, 0, 0, 0);
        add(U,    NONE,  0, 2, 0, 1, 0, 3);
        add(NONE, NONE,  0, 2, 0, 1, 0, 2);
        add(U,    NONE,  0, 2, 0, 1, 0, 1);  // level_up in TRANS discarded
        add(NONE, NONE,  0, 2, 1, 0, 0, 0);
        add(NONE, NONE,  0, 2, 1, 0, 0, 0);
        add(NONE, A | U, 0, 1, 0, 0, 0, 0);  // abort beats level_up in the tick cycle
        add(NONE, S,     0, 1, 1, 0, 0, 0);  // start in the tick cycle counts
        add(U,    NONE,  0, 2, 0, 1, 0, 3);
        add(NONE, NONE,  0, 2, 0, 1, 0, 2);
        add(NONE, NONE,  0, 2, 0, 1, 0, 1);
        add(NONE, NONE,  0, 2, 1, 0, 0, 0);
        add(U,    NONE,  0, 3, 0, 1, 0, 3);
        add(NONE, NONE,  0, 3, 0, 1, 0, 2);
        add(NONE, NONE,  0, 3, 0, 1, 0, 1);
        add(NONE, NONE,  0, 3, 1, 0, 0, 0);
        add(U,    NONE,  0, 3, 0, 0, 1, 0);  // up at MAX_LEVEL wins
        add(U,    NONE,  0, 3, 0, 0, 1, 0);
        add(S | U, NONE, 0, 1, 1, 0, 0, 0);  // start beats level_up in WIN
        add(A,    NONE,  1, 1, 0, 0, 0, 0);  // wide abort is a single request
        add(S,    NONE,  0, 1, 1, 0, 0, 0);
        add(U,    NONE,  0, 2, 0, 1, 0, 3);
        add(A,    NONE,  0, 1, 0, 0, 0, 0);  // abort out of TRANS

        add(S,    NONE,  0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(NONE, NONE, 0, 1, 1, 0, 0, 0);
`ifdef LEVEL_AUTO_ADVANCE_EN
        add(NONE, NONE,  0, 2, 0, 1, 0, 3);  // 5th tick in PLAY auto-advances
        add(NONE, NONE,  0, 2, 0, 1, 0, 2);
        add(NONE, NONE,  0, 2, 0, 1, 0, 1);
        add(NONE, NONE,  0, 2, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(NONE, NONE, 0, 2, 1, 0, 0, 0);
        add(NONE, U,     0, 3, 0, 1, 0, 3);  // explicit + auto on one tick: single step
`else
        for (int i = 0; i < 4; i++) add(NONE, NONE, 0, 1, 1, 0, 0, 0);
        add(NONE, U,     0, 2, 0, 1, 0, 3);
`endif

        for (int i = 0; i < vecs.size(); i++) run_frame(vecs[i], i);

        // Asynchronous reset mid-cycle from TRANS.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async reset level", {4'b0, level}, 8'd1);
        check("async reset in_transition", {7'b0, in_transition}, 8'd0);
        check("async reset frames_left", frames_left, 8'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
